imem_boot_loader: RTL and testbench

Byte-stream program loader upstream of the single-cycle RV32I core. Receives a length-prefixed little-endian image over a valid/ready byte interface and packs it into 32-bit words. Writes each word into instruction memory at consecutive word addresses. Holds the core in reset until the full image is written, then releases it.

---
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image, writes it
// word by word into instruction memory, and holds the core in reset until done.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned CAP_WORDS = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic [15:0]         words_loaded_q, words_loaded_d;

  logic                accept;
  logic [15:0]         len_in;

  assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign accept   = rx_valid && rx_ready;
  assign len_in   = {rx_data, len_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_LEN_LO;
      len_lo_q       <= '0;
      len_q          <= '0;
      word_idx_q     <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      core_rst_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      len_lo_q       <= len_lo_d;
      len_q          <= len_d;
      word_idx_q     <= word_idx_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_rst_q     <= core_rst_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    word_idx_d     = word_idx_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    // Status flags trail the state by one edge so the last write lands first.
    core_rst_d     = (state_q != S_DONE);
    load_done_d    = (state_q == S_DONE);
    load_err_d     = (state_q == S_ERR);
    words_loaded_d = words_loaded_q + 16'(imem_we_q);

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_in;
          if (len_in == 16'd0) begin
            state_d = S_DONE;
          end else if (32'(len_in) > CAP_WORDS) begin
            state_d = S_ERR;
          end else begin
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              imem_wdata_d = {rx_data, asm_q};
              imem_addr_d  = word_idx_q;
              imem_we_d    = 1'b1;
              word_idx_d   = word_idx_q + ADDR_W'(1);
              if (16'(word_idx_q) == (len_q - 16'd1)) begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal, gappy, zero-length, oversize
// and mid-load reset scenarios against hand-computed expectations.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [7:0]  stream [0:9];

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Instruction-memory model: log every write strobe seen at a clock edge.
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_log.push_back(imem_addr);
      wr_data_log.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then return 1 time unit after the edge for sampling.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_rx_ready"},  32'(rx_ready), 32'd1);
    chk({pfx, "_we"},        32'(imem_we), 32'd0);
    chk({pfx, "_addr"},      32'(imem_addr), 32'd0);
    chk({pfx, "_wdata"},     imem_wdata, 32'd0);
    chk({pfx, "_core_rst"},  32'(core_rst), 32'd1);
    chk({pfx, "_done"},      32'(load_done), 32'd0);
    chk({pfx, "_err"},       32'(load_err), 32'd0);
    chk({pfx, "_words"},     32'(words_loaded), 32'd0);
  endtask

  initial begin
    int base;
    stream[0] = 8'h02; stream[1] = 8'h00;
    stream[2] = 8'h13; stream[3] = 8'h05; stream[4] = 8'hA0; stream[5] = 8'h00;
    stream[6] = 8'h93; stream[7] = 8'h05; stream[8] = 8'h50; stream[9] = 8'h00;

    // Reset state
    do_reset();
    check_reset_values("rst0");

    // Two-word load, one byte per cycle, with cycle-exact checks
    base = wr_addr_log.size();
    for (int i = 0; i < 6; i++) step(1'b1, stream[i]);
    chk("w0_we",    32'(imem_we), 32'd1);
    chk("w0_addr",  32'(imem_addr), 32'd0);
    chk("w0_wdata", imem_wdata, 32'h00A00513);
    chk("w0_rst",   32'(core_rst), 32'd1);
    step(1'b1, stream[6]);
    chk("w0_we_pulse", 32'(imem_we), 32'd0);
    chk("w0_words",    32'(words_loaded), 32'd1);
    step(1'b1, stream[7]);
    step(1'b1, stream[8]);
    chk("w1_pre_we", 32'(imem_we), 32'd0);
    step(1'b1, stream[9]);
    chk("w1_we",       32'(imem_we), 32'd1);
    chk("w1_addr",     32'(imem_addr), 32'd1);
    chk("w1_wdata",    imem_wdata, 32'h00500593);
    chk("w1_core_rst", 32'(core_rst), 32'd1);
    chk("w1_done",     32'(load_done), 32'd0);
    chk("w1_ready",    32'(rx_ready), 32'd0);
    step(1'b0, 8'h00);
    chk("rel_core_rst", 32'(core_rst), 32'd0);
    chk("rel_done",     32'(load_done), 32'd1);
    chk("rel_words",    32'(words_loaded), 32'd2);
    chk("rel_we",       32'(imem_we), 32'd0);
    step(1'b1, 8'hFF);
    chk("rel_ready",    32'(rx_ready), 32'd0);
    chk("rel_wr_count", 32'(wr_addr_log.size() - base), 32'd2);
    chk("rel_hold_addr",  32'(imem_addr), 32'd1);
    chk("rel_hold_wdata", imem_wdata, 32'h00500593);

    // Same stream with random rx_valid gaps
    do_reset();
    base = wr_addr_log.size();
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
        step(1'b0, 8'($urandom_range(0, 255)));
      end
      step(1'b1, stream[i]);
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("gap_wr_count", 32'(wr_addr_log.size() - base), 32'd2);
    if (wr_addr_log.size() - base == 2) begin
      chk("gap_addr0",  32'(wr_addr_log[base]), 32'd0);
      chk("gap_data0",  wr_data_log[base], 32'h00A00513);
      chk("gap_addr1",  32'(wr_addr_log[base+1]), 32'd1);
      chk("gap_data1",  wr_data_log[base+1], 32'h00500593);
    end
    chk("gap_words",    32'(words_loaded), 32'd2);
    chk("gap_done",     32'(load_done), 32'd1);
    chk("gap_core_rst", 32'(core_rst), 32'd0);
    chk("gap_ready",    32'(rx_ready), 32'd0);

    // Zero-length image
    do_reset();
    base = wr_addr_log.size();
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk("z_core_rst_hold", 32'(core_rst), 32'd1);
    chk("z_ready",         32'(rx_ready), 32'd0);
    step(1'b0, 8'h00);
    chk("z_core_rst", 32'(core_rst), 32'd0);
    chk("z_done",     32'(load_done), 32'd1);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    chk("z_wr_count", 32'(wr_addr_log.size() - base), 32'd0);
    chk("z_words",    32'(words_loaded), 32'd0);

    // Oversize image: 257 words > 256 capacity
    do_reset();
    base = wr_addr_log.size();
    step(1'b1, 8'h01);
    step(1'b1, 8'h01);
    chk("e_ready", 32'(rx_ready), 32'd0);
    step(1'b0, 8'h00);
    chk("e_err",      32'(load_err), 32'd1);
    chk("e_core_rst", 32'(core_rst), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1));
    chk("e_wr_count", 32'(wr_addr_log.size() - base), 32'd0);
    chk("e_done",     32'(load_done), 32'd0);
    chk("e_err_hold", 32'(load_err), 32'd1);

    // Exact capacity (256 words) is accepted
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    chk("cap_ready", 32'(rx_ready), 32'd1);
    step(1'b0, 8'h00);
    chk("cap_err",   32'(load_err), 32'd0);

    // Reset after the first word, mid-second-word
    do_reset();
    base = wr_addr_log.size();
    for (int i = 0; i < 6; i++) step(1'b1, stream[i]);
    step(1'b1, stream[6]);
    rst = 1'b1;
    #1;
    check_reset_values("mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_wr_count", 32'(wr_addr_log.size() - base), 32'd1);
    if (wr_addr_log.size() - base == 1) begin
      chk("mid_addr0", 32'(wr_addr_log[base]), 32'd0);
    end
    base = wr_addr_log.size();
    for (int i = 0; i < 10; i++) step(1'b1, stream[i]);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("replay_wr_count", 32'(wr_addr_log.size() - base), 32'd2);
    chk("replay_words",    32'(words_loaded), 32'd2);
    chk("replay_done",     32'(load_done), 32'd1);
    chk("replay_core_rst", 32'(core_rst), 32'd0);

    // Holding reset forces core reset regardless of prior state
    rst = 1'b1;
    #1;
    chk("hold_core_rst", 32'(core_rst), 32'd1);
    chk("hold_done",     32'(load_done), 32'd0);
    step(1'b0, 8'h00);
    chk("hold_core_rst2", 32'(core_rst), 32'd1);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
